// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer: owns both CP0 write ports, sequences EPC/Cause/Status
// on exception entry and ERET, and arbitrates pipeline MTC0 writes against them.
module cp0_exc_ctrl #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [4:0]  REG_STATUS = 5'd12,
    parameter logic [4:0]  REG_CAUSE  = 5'd13,
    parameter logic [4:0]  REG_EPC    = 5'd14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  hw_int,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        eret_req,
    input  logic        mtc0_req,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_data,
    output logic        mtc0_gnt,
    output logic        stall,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic [4:0]  cp0_a2,
    output logic [4:0]  cp0_a3,
    output logic [31:0] cp0_wd1,
    output logic [31:0] cp0_wd2,
    output logic [1:0]  cp0_wr
);

    typedef enum logic [1:0] {S_IDLE, S_SAVE, S_MASK, S_ERET} state_t;

    state_t      state;
    logic [31:0] status_q;
    logic [31:0] epc_q;
    logic [4:0]  cap_code;
    logic [31:0] cap_pc;
    logic [5:0]  cap_int;
    logic        int_pend;

    assign int_pend = (|(hw_int & status_q[15:10])) & status_q[0] & ~status_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            status_q <= '0;
            epc_q    <= '0;
            cap_code <= '0;
            cap_pc   <= '0;
            cap_int  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (exc_req || int_pend) begin
                        cap_code <= exc_req ? exc_code : 5'd0;
                        cap_pc   <= exc_pc;
                        cap_int  <= hw_int;
                        state    <= S_SAVE;
                    end else if (eret_req) begin
                        state <= S_ERET;
                    end else if (mtc0_req) begin
                        if (mtc0_addr == REG_STATUS) status_q <= mtc0_data;
                        if (mtc0_addr == REG_EPC)    epc_q    <= mtc0_data;
                    end
                end
                S_SAVE: begin
                    epc_q <= cap_pc;
                    state <= S_MASK;
                end
                S_MASK: begin
                    status_q <= status_q | 32'h2;
                    state    <= S_IDLE;
                end
                S_ERET: begin
                    status_q <= status_q & ~32'h2;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are combinational; reset gates them so nothing leaks while it is held.
    always_comb begin
        mtc0_gnt    = 1'b0;
        stall       = 1'b0;
        pc_redirect = 1'b0;
        redirect_pc = '0;
        cp0_a2      = '0;
        cp0_a3      = '0;
        cp0_wd1     = '0;
        cp0_wd2     = '0;
        cp0_wr      = 2'b00;
        if (!reset) begin
            case (state)
                S_IDLE: begin
                    if (exc_req || int_pend || eret_req) begin
                        stall = 1'b1;
                    end else if (mtc0_req) begin
                        mtc0_gnt = 1'b1;
                        cp0_wr   = 2'b01;
                        cp0_a3   = mtc0_addr;
                        cp0_wd2  = mtc0_data;
                    end
                end
                S_SAVE: begin
                    stall   = 1'b1;
                    cp0_wr  = 2'b11;
                    cp0_a2  = REG_EPC;
                    cp0_wd1 = cap_pc;
                    cp0_a3  = REG_CAUSE;
                    cp0_wd2 = {16'b0, cap_int, 3'b0, cap_code, 2'b0};
                end
                S_MASK: begin
                    stall       = 1'b1;
                    cp0_wr      = 2'b01;
                    cp0_a3      = REG_STATUS;
                    cp0_wd2     = status_q | 32'h2;
                    pc_redirect = 1'b1;
                    redirect_pc = HANDLER_PC;
                end
                S_ERET: begin
                    stall       = 1'b1;
                    cp0_wr      = 2'b01;
                    cp0_a3      = REG_STATUS;
                    cp0_wd2     = status_q & ~32'h2;
                    pc_redirect = 1'b1;
                    redirect_pc = epc_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios then randomized traffic, checked against a
// transaction-level model that schedules the expected output of each future cycle.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  hw_int;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        eret_req;
    logic        mtc0_req;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_data;
    logic        mtc0_gnt;
    logic        stall;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic [4:0]  cp0_a2;
    logic [4:0]  cp0_a3;
    logic [31:0] cp0_wd1;
    logic [31:0] cp0_wd2;
    logic [1:0]  cp0_wr;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    cp0_exc_ctrl #(
        .HANDLER_PC(32'h0000_4180),
        .REG_STATUS(5'd12),
        .REG_CAUSE (5'd13),
        .REG_EPC   (5'd14)
    ) dut (
        .clk(clk), .reset(reset), .hw_int(hw_int), .exc_req(exc_req), .exc_code(exc_code),
        .exc_pc(exc_pc), .eret_req(eret_req), .mtc0_req(mtc0_req), .mtc0_addr(mtc0_addr),
        .mtc0_data(mtc0_data), .mtc0_gnt(mtc0_gnt), .stall(stall), .pc_redirect(pc_redirect),
        .redirect_pc(redirect_pc), .cp0_a2(cp0_a2), .cp0_a3(cp0_a3), .cp0_wd1(cp0_wd1),
        .cp0_wd2(cp0_wd2), .cp0_wr(cp0_wr)
    );

    always #5 clk = ~clk;

    // Expected outputs of one cycle plus the architectural effect that cycle commits.
    typedef struct {
        logic        stall;
        logic        redir;
        logic        gnt;
        logic [1:0]  wr;
        logic [31:0] rpc;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic [31:0] wd1;
        logic [31:0] wd2;
        logic        set_st;
        logic [31:0] st;
        logic        set_epc;
        logic [31:0] epc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_status;
    logic [31:0] m_epc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_status = '0;
        m_epc    = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
        chk({tag, "_redir"}, {31'b0, pc_redirect}, 32'd0);
        chk({tag, "_gnt"},   {31'b0, mtc0_gnt}, 32'd0);
        chk({tag, "_wr"},    {30'b0, cp0_wr}, 32'd0);
        chk({tag, "_rpc"},   redirect_pc, 32'd0);
        chk({tag, "_wd1"},   cp0_wd1, 32'd0);
        chk({tag, "_wd2"},   cp0_wd2, 32'd0);
        chk({tag, "_a23"},   {22'b0, cp0_a2, cp0_a3}, 32'd0);
    endtask

    // Predicts this cycle's outputs from the current inputs, compares, then commits effects.
    task automatic model_cycle();
        exp_t e, s, m;
        logic pend;
        e = '{default: '0};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            pend = (|(hw_int & m_status[15:10])) && m_status[0] && !m_status[1];
            if (exc_req || pend) begin
                e.stall = 1'b1;
                s = '{default: '0};
                s.stall = 1'b1; s.wr = 2'b11;
                s.a2 = 5'd14; s.wd1 = exc_pc;
                s.a3 = 5'd13;
                s.wd2 = (32'(hw_int) << 10) | (32'(exc_req ? exc_code : 5'd0) << 2);
                s.set_epc = 1'b1; s.epc = exc_pc;
                m = '{default: '0};
                m.stall = 1'b1; m.wr = 2'b01; m.a3 = 5'd12;
                m.wd2 = m_status | 32'h2;
                m.redir = 1'b1; m.rpc = 32'h0000_4180;
                m.set_st = 1'b1; m.st = m_status | 32'h2;
                exp_q.push_back(s);
                exp_q.push_back(m);
            end else if (eret_req) begin
                e.stall = 1'b1;
                m = '{default: '0};
                m.stall = 1'b1; m.wr = 2'b01; m.a3 = 5'd12;
                m.wd2 = m_status & ~32'h2;
                m.redir = 1'b1; m.rpc = m_epc;
                m.set_st = 1'b1; m.st = m_status & ~32'h2;
                exp_q.push_back(m);
            end else if (mtc0_req) begin
                e.gnt = 1'b1; e.wr = 2'b01; e.a3 = mtc0_addr; e.wd2 = mtc0_data;
                e.set_st  = (mtc0_addr == 5'd12); e.st  = mtc0_data;
                e.set_epc = (mtc0_addr == 5'd14); e.epc = mtc0_data;
            end
        end
        chk("stall", {31'b0, stall}, {31'b0, e.stall});
        chk("redirect", {31'b0, pc_redirect}, {31'b0, e.redir});
        chk("mtc0_gnt", {31'b0, mtc0_gnt}, {31'b0, e.gnt});
        chk("cp0_wr", {30'b0, cp0_wr}, {30'b0, e.wr});
        if (e.redir) chk("redirect_pc", redirect_pc, e.rpc);
        if (e.wr[1]) begin
            chk("cp0_a2", {27'b0, cp0_a2}, {27'b0, e.a2});
            chk("cp0_wd1", cp0_wd1, e.wd1);
        end
        if (e.wr[0]) begin
            chk("cp0_a3", {27'b0, cp0_a3}, {27'b0, e.a3});
            chk("cp0_wd2", cp0_wd2, e.wd2);
        end
        if (e.wr == 2'b11) chk("addr_distinct", {31'b0, cp0_a2 == cp0_a3}, 32'd0);
        if (e.set_st)  m_status = e.st;
        if (e.set_epc) m_epc    = e.epc;
    endtask

    task automatic drive_cycle(input logic [5:0] hi, input logic ex, input logic [4:0] ec,
                               input logic [31:0] epc, input logic er, input logic mr,
                               input logic [4:0] ma, input logic [31:0] md);
        @(negedge clk);
        hw_int = hi; exc_req = ex; exc_code = ec; exc_pc = epc;
        eret_req = er; mtc0_req = mr; mtc0_addr = ma; mtc0_data = md;
        #1;
        model_cycle();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_zero({tag, "_held"});
        model_reset();
        @(posedge clk);
        #1;
        chk_zero({tag, "_after_edge"});
        @(negedge clk);
        reset = 1'b0;
        hw_int = '0; exc_req = 1'b0; eret_req = 1'b0; mtc0_req = 1'b0;
        #1;
        model_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        reset = 1'b1;
        hw_int = '0; exc_req = 1'b0; exc_code = '0; exc_pc = '0;
        eret_req = 1'b0; mtc0_req = 1'b0; mtc0_addr = '0; mtc0_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // MTC0 Status write in IDLE
        drive_cycle(6'b0, 0, 5'd0, 32'h0, 0, 1, 5'd12, 32'h0000_0401);
        chk("t1_gnt", {31'b0, mtc0_gnt}, 32'd1);
        chk("t1_wd2", cp0_wd2, 32'h401);

        // Interrupt entry on IM[0]: entry cycle, SAVE, MASK
        drive_cycle(6'b000001, 0, 5'd0, 32'h3010, 0, 0, 5'd0, 32'h0);
        drive_cycle(6'b000001, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
        chk("t2_epc", cp0_wd1, 32'h3010);
        chk("t2_cause", cp0_wd2, 32'h0000_0400);
        drive_cycle(6'b000001, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
        chk("t2_status", cp0_wd2, 32'h403);
        chk("t2_vector", redirect_pc, 32'h4180);

        // EXL masks the held line; ERET then re-enters on the first IDLE cycle
        drive_cycle(6'b000001, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
        chk("t5_masked", {31'b0, stall}, 32'd0);
        drive_cycle(6'b000001, 0, 5'd0, 32'h0, 1, 0, 5'd0, 32'h0);
        drive_cycle(6'b000001, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
        chk("t5_eret_status", cp0_wd2, 32'h401);
        drive_cycle(6'b000001, 0, 5'd0, 32'h3044, 0, 0, 5'd0, 32'h0);
        chk("t5_reentry", {31'b0, stall}, 32'd1);
        drive_cycle(6'b0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
        drive_cycle(6'b0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);

        // Exception with EXL=1 and a colliding MTC0
        drive_cycle(6'b0, 1, 5'd12, 32'h3020, 0, 1, 5'd12, 32'hFFFF_FFFF);
        chk("t3_gnt", {31'b0, mtc0_gnt}, 32'd0);
        drive_cycle(6'b0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
        chk("t3_cause", cp0_wd2, 32'h30);
        chk("t3_epc", cp0_wd1, 32'h3020);
        drive_cycle(6'b0, 0, 5'd0, 32'h0, 1, 1, 5'd14, 32'h0);

        // ERET back to 0x3020
        drive_cycle(6'b0, 0, 5'd0, 32'h0, 1, 0, 5'd0, 32'h0);
        drive_cycle(6'b0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
        chk("t4_status", cp0_wd2, 32'h401);
        chk("t4_target", redirect_pc, 32'h3020);

        // Reset during MASK, then ERET shows zeroed shadows
        drive_cycle(6'b0, 1, 5'd4, 32'h5000, 0, 0, 5'd0, 32'h0);
        drive_cycle(6'b0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
        do_reset("t6");
        drive_cycle(6'b111111, 0, 5'd0, 32'h0, 1, 0, 5'd0, 32'h0);
        drive_cycle(6'b111111, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
        chk("t6_target", redirect_pc, 32'h0);
        chk("t6_status", cp0_wd2, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [4:0] a;
            if ($urandom_range(0, 149) == 0) begin
                do_reset("rnd_reset");
            end else begin
                case ($urandom_range(0, 3))
                    0: a = 5'd12;
                    1: a = 5'd13;
                    2: a = 5'd14;
                    default: a = 5'($urandom);
                endcase
                rd = $urandom;
                if (a == 5'd12 && $urandom_range(0, 3) != 0) rd[1] = 1'b0;
                drive_cycle(($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b0,
                            $urandom_range(0, 9) == 0, 5'($urandom), $urandom,
                            $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, a, rd);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
